// File: rtl/inst_loader_if.sv
// Byte-stream, instruction-memory and status signals of the program loader.
// The loader uses the slave view; the host/memory side uses the master view.
interface inst_loader_if;
   logic       start;
   logic       byte_valid;
   logic [7:0] byte_data;
   logic       byte_ready;
   logic [3:0] mem_addr;
   logic       mem_we;
   logic       mem_re;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata;
   logic       cpu_hold;
   logic       done;
   logic       error;

   modport master (
      output start, byte_valid, byte_data, mem_rdata,
      input  byte_ready, mem_addr, mem_we, mem_re, mem_wdata, cpu_hold, done, error
   );

   modport slave (
      input  start, byte_valid, byte_data, mem_rdata,
      output byte_ready, mem_addr, mem_we, mem_re, mem_wdata, cpu_hold, done, error
   );
endinterface

// File: rtl/inst_loader.sv
// Loads a length-prefixed, checksummed byte image into the 16-entry instruction
// memory, reads it back to verify it, and holds the CPU until the image is good.
module inst_loader (
   input  logic         clk,
   input  logic         rst,
   inst_loader_if.slave bus
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] LEN    = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] CSUM   = 3'd3;
   localparam logic [2:0] VERIFY = 3'd4;
   localparam logic [2:0] DONE   = 3'd5;
   localparam logic [2:0] ERROR  = 3'd6;

   logic [2:0] state_r;
   logic [4:0] len_r;
   logic [4:0] idx_r;
   logic [4:0] rd_idx_r;
   logic [4:0] cap_cnt_r;
   logic [7:0] csum_r;
   logic [7:0] rb_sum_r;
   logic       rd_valid_r;
   logic       mem_we_r;
   logic       mem_re_r;
   logic [3:0] mem_addr_r;
   logic [7:0] mem_wdata_r;
   logic       cpu_hold_r;
   logic       done_r;
   logic       error_r;

   logic       ready_s;
   logic       accept_s;
   logic [7:0] rb_next_s;

   // Byte acceptance is open only while the stream is being consumed
   always_comb begin
      ready_s = 1'b0;
      case (state_r)
         LEN, DATA, CSUM: ready_s = 1'b1;
         default:         ready_s = 1'b0;
      endcase
   end

   assign accept_s  = bus.byte_valid && ready_s;
   assign rb_next_s = rb_sum_r + bus.mem_rdata;

   // Session FSM, memory port registers and readback verification
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         len_r       <= 5'd0;
         idx_r       <= 5'd0;
         rd_idx_r    <= 5'd0;
         cap_cnt_r   <= 5'd0;
         csum_r      <= 8'd0;
         rb_sum_r    <= 8'd0;
         rd_valid_r  <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_re_r    <= 1'b0;
         mem_addr_r  <= 4'd0;
         mem_wdata_r <= 8'd0;
         cpu_hold_r  <= 1'b1;
         done_r      <= 1'b0;
         error_r     <= 1'b0;
      end else begin
         mem_we_r   <= 1'b0;
         mem_re_r   <= 1'b0;
         rd_valid_r <= mem_re_r;
         case (state_r)
            IDLE: begin
               if (bus.start) begin
                  state_r <= LEN;
               end
            end
            LEN: begin
               if (accept_s) begin
                  if ((bus.byte_data != 8'd0) && (bus.byte_data <= 8'd16)) begin
                     len_r   <= bus.byte_data[4:0];
                     idx_r   <= 5'd0;
                     state_r <= DATA;
                  end else begin
                     error_r <= 1'b1;
                     state_r <= ERROR;
                  end
               end
            end
            DATA: begin
               if (accept_s) begin
                  mem_we_r    <= 1'b1;
                  mem_addr_r  <= idx_r[3:0];
                  mem_wdata_r <= bus.byte_data;
                  idx_r       <= idx_r + 5'd1;
                  if ((idx_r + 5'd1) == len_r) begin
                     state_r <= CSUM;
                  end
               end
            end
            CSUM: begin
               // The first readback is issued right away so VERIFY spans N+1 cycles
               if (accept_s) begin
                  csum_r     <= bus.byte_data;
                  mem_re_r   <= 1'b1;
                  mem_addr_r <= 4'd0;
                  rd_idx_r   <= 5'd1;
                  cap_cnt_r  <= 5'd0;
                  rb_sum_r   <= 8'd0;
                  state_r    <= VERIFY;
               end
            end
            VERIFY: begin
               if (rd_idx_r < len_r) begin
                  mem_re_r   <= 1'b1;
                  mem_addr_r <= rd_idx_r[3:0];
                  rd_idx_r   <= rd_idx_r + 5'd1;
               end
               // rd_valid_r marks the cycle in which mem_rdata answers the previous read
               if (rd_valid_r) begin
                  rb_sum_r  <= rb_next_s;
                  cap_cnt_r <= cap_cnt_r + 5'd1;
                  if ((cap_cnt_r + 5'd1) == len_r) begin
                     if (rb_next_s == csum_r) begin
                        done_r     <= 1'b1;
                        cpu_hold_r <= 1'b0;
                        state_r    <= DONE;
                     end else begin
                        error_r <= 1'b1;
                        state_r <= ERROR;
                     end
                  end
               end
            end
            DONE, ERROR: begin
               if (bus.start) begin
                  done_r     <= 1'b0;
                  error_r    <= 1'b0;
                  cpu_hold_r <= 1'b1;
                  state_r    <= LEN;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign bus.byte_ready = ready_s;
   assign bus.mem_addr   = mem_addr_r;
   assign bus.mem_we     = mem_we_r;
   assign bus.mem_re     = mem_re_r;
   assign bus.mem_wdata  = mem_wdata_r;
   assign bus.cpu_hold   = cpu_hold_r;
   assign bus.done       = done_r;
   assign bus.error      = error_r;

endmodule

// File: tb/tb_inst_loader.sv
// Scoreboard bench for inst_loader: the driver pushes expected writes and outcomes
// from a stream-level model; a negedge monitor pops and compares them.
module tb_inst_loader;

   logic clk = 1'b0;
   logic rst;

   inst_loader_if bus ();

   inst_loader dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   logic [7:0]  imem [16];
   logic [7:0]  stim [$];
   logic [11:0] exp_wr [$];
   bit          res_q [$];
   int          n_checks = 0;
   int          n_err    = 0;
   int          re_cnt   = 0;
   bit          in_payload = 1'b0;
   bit          prev_acc   = 1'b0;
   bit          prev_done  = 1'b0;
   bit          prev_error = 1'b0;
   logic [11:0] w;
   bit          e;

   // Synchronous instruction memory: read data appears the cycle after mem_re
   always @(posedge clk) begin
      if (bus.mem_we) imem[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_re) bus.mem_rdata <= imem[bus.mem_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: write/read scoreboard, write latency, invariants, outcome queue
   always @(negedge clk) begin
      if (bus.mem_we) begin
         if (exp_wr.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                     bus.mem_addr, bus.mem_wdata);
         end else begin
            w = exp_wr.pop_front();
            chk("write_addr", 32'(bus.mem_addr), 32'(w[11:8]));
            chk("write_data", 32'(bus.mem_wdata), 32'(w[7:0]));
         end
      end
      if (bus.mem_re) begin
         chk("read_addr", 32'(bus.mem_addr), 32'(re_cnt[3:0]));
         re_cnt++;
      end
      if (rst) begin
         prev_acc = 1'b0;
      end else begin
         chk("we_latency", 32'(bus.mem_we), 32'(prev_acc));
         chk("we_re_exclusive", 32'(bus.mem_we & bus.mem_re), 32'd0);
         chk("hold_vs_done", 32'(bus.cpu_hold), 32'(!bus.done));
         if ((bus.done && !prev_done) || (bus.error && !prev_error)) begin
            if (res_q.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL outcome: done=%0d error=%0d, expected no outcome", bus.done, bus.error);
            end else begin
               e = res_q.pop_front();
               chk("outcome", 32'({bus.error, bus.done}), e ? 32'd2 : 32'd1);
            end
         end
         prev_acc = bus.byte_valid && bus.byte_ready && in_payload;
      end
      prev_done  = bus.done;
      prev_error = bus.error;
   end

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int g;
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      bus.byte_valid = 1'b1;
      bus.byte_data  = b;
      g = 0;
      while (!bus.byte_ready && g < 50) begin
         @(posedge clk); #1;
         g++;
      end
      if (g >= 50) begin
         n_checks++;
         n_err++;
         $display("FAIL byte_accept: byte_ready low for %0d cycles, expected high", g);
      end
      @(posedge clk); #1;
      bus.byte_valid = 1'b0;
   endtask

   task automatic pulse_start();
      bus.start      = 1'b1;
      bus.byte_valid = 1'b1;
      bus.byte_data  = 8'($urandom);
      @(posedge clk); #1;
      bus.start      = 1'b0;
      bus.byte_valid = 1'b0;
   endtask

   // Reference model: derive writes and verdict from stim, then drive the session
   task automatic run_session(input bit gaps, input bit mid_start);
      int n, c;
      logic [7:0] s;
      bit bad;
      n   = int'(stim[0]);
      bad = (n == 0) || (n > 16);
      s   = 8'd0;
      if (!bad) begin
         for (int k = 1; k <= n; k++) begin
            s = s + stim[k];
            exp_wr.push_back({4'(k - 1), stim[k]});
         end
      end
      res_q.push_back(bad || (s != stim[n + 1]));
      pulse_start();
      chk("start_done", 32'(bus.done), 32'd0);
      chk("start_error", 32'(bus.error), 32'd0);
      chk("start_hold", 32'(bus.cpu_hold), 32'd1);
      chk("start_ready", 32'(bus.byte_ready), 32'd1);
      re_cnt = 0;
      send_byte(stim[0], gaps);
      if (!bad) begin
         in_payload = 1'b1;
         for (int k = 1; k <= n; k++) begin
            if (mid_start && k == 1) begin
               bus.start = 1'b1;
               @(posedge clk); #1;
               bus.start = 1'b0;
            end
            send_byte(stim[k], gaps);
         end
         in_payload = 1'b0;
         send_byte(stim[n + 1], gaps);
      end
      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (!(bus.done || bus.error) && c < 200);
      chk("result_latency", 32'(c), bad ? 32'd1 : 32'(n + 2));
      chk("readback_count", 32'(re_cnt), bad ? 32'd0 : 32'(n));
      chk("writes_drained", 32'(exp_wr.size()), 32'd0);
      chk("ready_after_end", 32'(bus.byte_ready), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      int n;
      logic [7:0] s, v;
      rst = 1'b1;
      bus.start = 1'b0;
      bus.byte_valid = 1'b0;
      bus.byte_data = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_hold", 32'(bus.cpu_hold), 32'd1);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_error", 32'(bus.error), 32'd0);
      chk("rst_we", 32'(bus.mem_we), 32'd0);
      chk("rst_re", 32'(bus.mem_re), 32'd0);
      chk("rst_addr", 32'(bus.mem_addr), 32'd0);
      chk("rst_wdata", 32'(bus.mem_wdata), 32'd0);
      chk("rst_ready", 32'(bus.byte_ready), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      stim = '{8'h03, 8'h12, 8'h34, 8'h56, 8'h9C};
      run_session(1'b0, 1'b0);

      stim.delete();
      stim.push_back(8'h10);
      for (int k = 0; k < 16; k++) stim.push_back(8'(k));
      stim.push_back(8'h78);
      run_session(1'b1, 1'b0);

      stim = '{8'h00};
      run_session(1'b0, 1'b0);
      stim = '{8'h11};
      run_session(1'b0, 1'b0);

      stim = '{8'h02, 8'hAA, 8'h01, 8'h00};
      run_session(1'b0, 1'b0);

      stim = '{8'h01, 8'h7F, 8'h7F};
      run_session(1'b0, 1'b0);
      run_session(1'b0, 1'b1);

      // Reset lands on the cycle the third of four payload bytes is offered
      pulse_start();
      re_cnt = 0;
      send_byte(8'h04, 1'b0);
      in_payload = 1'b1;
      exp_wr.push_back({4'd0, 8'h21});
      exp_wr.push_back({4'd1, 8'h43});
      send_byte(8'h21, 1'b0);
      send_byte(8'h43, 1'b0);
      bus.byte_valid = 1'b1;
      bus.byte_data  = 8'h65;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      bus.byte_valid = 1'b0;
      in_payload = 1'b0;
      chk("midrst_hold", 32'(bus.cpu_hold), 32'd1);
      chk("midrst_done", 32'(bus.done), 32'd0);
      chk("midrst_error", 32'(bus.error), 32'd0);
      chk("midrst_ready", 32'(bus.byte_ready), 32'd0);
      chk("midrst_we", 32'(bus.mem_we), 32'd0);
      repeat (4) begin @(posedge clk); #1; end
      chk("midrst_writes", 32'(exp_wr.size()), 32'd0);
      stim = '{8'h04, 8'h21, 8'h43, 8'h65, 8'h87, 8'h50};
      run_session(1'b1, 1'b0);

      for (int r = 0; r < 25; r++) begin
         n = int'($urandom_range(0, 18));
         stim.delete();
         stim.push_back(8'(n));
         if (n >= 1 && n <= 16) begin
            s = 8'd0;
            for (int k = 0; k < n; k++) begin
               v = 8'($urandom);
               stim.push_back(v);
               s = s + v;
            end
            if ($urandom_range(0, 3) == 0) s = s + 8'($urandom_range(1, 255));
            stim.push_back(s);
         end
         run_session(1'b1, 1'($urandom_range(0, 1)));
      end

      chk("outcomes_drained", 32'(res_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/inst_loader.md
# inst_loader

Program loader that writes the 16-entry instruction memory the fetch stage reads. It accepts a length-prefixed, checksummed byte stream over a valid/ready handshake and writes each byte to consecutive instruction addresses. It then reads the image back to verify it and holds the processor until the image is confirmed good. It sits between a host/debug byte source and the write/read port of the instruction memory.

## Interface
Parameters: none (address width 4, data width 8, depth 16 fixed).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  single-cycle request to begin a load session
- byte_valid  input  1  byte_data holds a byte to transfer
- byte_data  input  8  stream byte (length, payload, checksum)
- byte_ready  output  1  loader accepts byte_data this cycle
- mem_addr  output  4  instruction memory address
- mem_we  output  1  memory write strobe
- mem_re  output  1  memory read enable
- mem_wdata  output  8  memory write data
- mem_rdata  input  8  memory read data; valid one cycle after mem_re with mem_addr
- cpu_hold  output  1  keeps the pipeline (pc busy) stalled while high
- done  output  1  image loaded and verified
- error  output  1  load failed (bad length or checksum mismatch)

## Operation
- States: IDLE, LEN, DATA, CSUM, VERIFY, DONE, ERROR.
- Byte transfer occurs on any cycle with byte_valid && byte_ready.
- byte_ready is combinational: 1 only in LEN, DATA, CSUM.
- IDLE: on start, go to LEN.
- LEN: accepted byte is the length N.
  - N in 1..16: store N, clear index and running sum, go to DATA.
  - N = 0 or N > 16: go to ERROR.
- DATA: each accepted byte writes to address index.
  - Registered mem_we=1, mem_addr=index, mem_wdata=byte in the following cycle.
  - index += 1; sum = (sum + byte) mod 256.
  - After the Nth byte, go to CSUM.
- CSUM: the accepted byte is stored as expected checksum; go to VERIFY.
- VERIFY: issue reads at addresses 0..N-1, one per cycle (mem_re=1).
  - Capture mem_rdata one cycle after each read and accumulate readback sum mod 256.
  - After the Nth capture, compare readback sum to expected checksum: equal goes to DONE, unequal goes to ERROR.
- DONE: done=1, cpu_hold=0.
- ERROR: error=1, cpu_hold=1.
- start in DONE or ERROR: clear done/error, set cpu_hold=1, go to LEN.
- start in LEN/DATA/CSUM/VERIFY is ignored.
- Memory is never written outside DATA; mem_we and mem_re are never both 1.

## Timing
- Reset values: state=IDLE, cpu_hold=1, done=0, error=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, byte_ready=0.
- rst mid-session returns to IDLE with the reset values above. A write strobe pending from the reset cycle is suppressed; memory contents are left as is.
- Throughput is one byte per cycle; back-to-back bytes are allowed. Gaps in byte_valid stall without side effects.
- Write latency: mem_we is asserted exactly 1 cycle after the accepting cycle, for 1 cycle.
- VERIFY lasts N+1 cycles. done or error rises on the cycle after the last readback capture.
- cpu_hold falls in the same cycle done rises.
- Sums are 8-bit and wrap modulo 256. index is 5 bits internally, so N=16 reaches 16 without aliasing; mem_addr uses index[3:0].
- start and byte_valid in the same IDLE cycle: only start is taken. The byte is not accepted because byte_ready=0 in IDLE.

## Test plan
- Normal load: start, then bytes 0x03, 0x12, 0x34, 0x56, 0x9C back-to-back. Expected: writes to addresses 0/1/2 of 0x12/0x34/0x56, readback of 3 addresses, done=1, cpu_hold=0, error=0.
- Full depth with gaps: length 0x10, payload 0x00..0x0F with random byte_valid gaps, checksum 0x78. Expected: 16 writes at addresses 0..15, done=1.
- Bad length: 0x00, and separately 0x11. Expected: ERROR immediately, no mem_we pulses, cpu_hold=1, byte_ready=0 afterward.
- Checksum mismatch: 0x02, 0xAA, 0x01, then checksum 0x00. Expected: both writes happen, verify completes, error=1, done=0, cpu_hold stays 1.
- Restart: from DONE, apply start and load 0x01, 0x7F, 0x7F. Expected: done clears on start, cpu_hold=1 during the session, done=1 at the end. A start pulse mid-DATA has no effect.
- Reset mid-load: rst after 2 of 4 payload bytes. Expected: IDLE, cpu_hold=1, no further mem_we; a subsequent full session succeeds.
